gpio_cmd_ctrl: RTL and testbench
================================

# gpio_cmd_ctrl

Command sequencer between the MicroBlaze GPIO word and the 2D-convolution datapath. It decodes the host's `{ctrl, valid, data}` fields and turns each `valid` rising edge into exactly one action:
- kernel row load
- image word write into the frame memory
- convolution start
- result readback

It tracks the write and read address counters and the run/done state, so the host never drives memory addresses directly. It sits inside `micro_sim` between the GPIO output field split and the memory/convolver instances.

## Interface
- `DATA_W`, 24, GPIO data field width and memory word width
- `CTRL_W`, 3, GPIO command field width
- `ADDR_W`, 10, frame-memory address width
- `LEN_W`, 10, image-length register width
- `KROWS`, 3, kernel rows per kernel load cycle

- `i_clock`  in  1  system clock
- `i_reset`  in  1  synchronous, active-low reset
- `i_gpio_data`  in  DATA_W  host data field
- `i_gpio_ctrl`  in  CTRL_W  host command field
- `i_gpio_valid`  in  1  host strobe level; one command per rising edge
- `o_kernel_data`  out  DATA_W  kernel row value
- `o_kernel_row`  out  2  kernel row index 0..KROWS-1
- `o_kernel_we`  out  1  kernel row write pulse
- `o_img_len`  out  LEN_W  image length (columns)
- `o_mem_wdata`  out  DATA_W  frame-memory write data
- `o_mem_waddr`  out  ADDR_W  frame-memory write address
- `o_mem_we`  out  1  frame-memory write pulse
- `o_mem_raddr`  out  ADDR_W  frame-memory read address
- `o_mem_re`  out  1  frame-memory read pulse
- `i_mem_rdata`  in  DATA_W  read data, valid 1 cycle after `o_mem_re`
- `o_conv_start`  out  1  convolver start pulse
- `i_conv_done`  in  1  convolver completion pulse
- `o_gpio_rdata`  out  DATA_W  readback word to host
- `o_gpio_rvalid`  out  1  readback word updated (1-cycle pulse)
- `o_busy`  out  1  high in RUN
- `o_err`  out  1  sticky protocol error
- `o_led`  out  1  equals `o_busy`

## Operation
Reset (`i_reset`=0 at a clock edge):
- All outputs 0, state IDLE.
- `wptr`, `rptr`, `krow` are 0; `o_img_len` is 0; `o_err` cleared.

Strobe generation:
- `i_gpio_valid` passes through a 2-flop synchronizer, then a rising-edge detect.
- `strobe` is high for one cycle per host pulse, however long the pulse is.
- `i_gpio_ctrl` and `i_gpio_data` are sampled in the `strobe` cycle. The host holds them stable across the pulse.

States: IDLE, RUN, DONE.

Commands, with `strobe` in IDLE or DONE (a command in DONE first moves to IDLE):
- 000 KERNEL:
  - `o_kernel_we` pulses, `o_kernel_row`=`krow`, `o_kernel_data`=data.
  - `krow` increments and wraps from KROWS-1 to 0.
- 001 LEN:
  - In IDLE, `o_img_len` loads `data[LEN_W-1:0]` every cycle while ctrl=001. No strobe is needed.
  - A strobe with 001 also loads it.
- 010 IMG:
  - `o_mem_we` pulses with `o_mem_waddr`=`wptr`, `o_mem_wdata`=data.
  - `wptr` increments.
- 100 IMG_LAST:
  - Same write as IMG.
  - Next cycle: `o_conv_start` pulses, `wptr`←0, state→RUN.
- 011 READ, valid only in DONE:
  - `o_mem_re` pulses with `o_mem_raddr`=`rptr`; `rptr` increments and wraps mod 2^ADDR_W.
  - One cycle later `o_gpio_rdata`←`i_mem_rdata` and `o_gpio_rvalid` pulses.
  - `o_gpio_rdata` holds until the next read or reset.
  - State stays DONE.
- 101, 110, 111: no action, `o_err`←1.

Protocol errors (each sets `o_err`, no other effect):
- Any strobe in RUN.
- READ in IDLE.
- IMG or IMG_LAST when `wptr` is all-ones and a write has already occurred at that address. The overflow write is suppressed; `wptr` does not wrap.

Transitions:
- RUN→DONE on `i_conv_done`; `rptr`←0.
- `i_conv_done` in IDLE or DONE is ignored.

Reset mid-RUN returns to IDLE with no `o_conv_start` reissue.

## Timing
- Sampling edge E is the first clock edge that sees `i_gpio_valid`=1.
- `strobe` is high in the cycle after edge E+1.
- Write, kernel and read pulses are registered and high in the cycle after edge E+2.
- `o_conv_start`: one cycle after the IMG_LAST `o_mem_we` cycle.
- `o_busy` rises in the same cycle as `o_conv_start`.
- `o_gpio_rvalid`: one cycle after `o_mem_re`.
- `o_busy` falls the cycle after `i_conv_done` is sampled.
- Every pulse output is exactly 1 cycle wide.
- Minimum strobe spacing: 3 cycles of `i_gpio_valid` low between pulses.

## Structure
- Package `conv_ctrl_pkg`: command codes `CMD_KERNEL`=000, `CMD_LEN`=001, `CMD_IMG`=010, `CMD_READ`=011, `CMD_IMG_LAST`=100; state encodings; default widths.
- Sub-module `gpio_strobe_sync`: 2-flop synchronizer plus rising-edge detect. It uses the same clock and reset.

## Test plan
- Reset mid-RUN: drive `i_reset`=0 for 1 edge during RUN → state IDLE, all outputs 0, no `o_conv_start` afterwards.
- Three KERNEL pulses with data 0x000, 0x010, 0x000 → three `o_kernel_we` pulses, rows 0, 1, 2 with matching data. A fourth KERNEL pulse → row 0.
- LEN then image load:
  - ctrl=001, data 0x00A held with no valid → `o_img_len`=10.
  - 39 IMG pulses with data i → writes at addr i = i.
  - IMG_LAST with data 0x27 → write at 39, then `o_conv_start` next cycle, `o_busy`=1.
- IMG strobe in RUN → no `o_mem_we`, `o_err`=1. Then `i_conv_done` → `o_busy`=0.
- After done, 40 READ pulses with memory preloaded addr=data → `o_gpio_rdata` 0..39 in order, each with one `o_gpio_rvalid`, `o_mem_re`→`o_gpio_rvalid` latency 1.
- ctrl=111 strobe in IDLE → `o_err`=1, no write/read pulses.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared widths, command codes, state encodings and payload types for the
// GPIO command sequencer feeding the 2D-convolution datapath.
package conv_ctrl_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned KROWS  = 3;
    localparam int unsigned KROW_W = 2;

    typedef enum logic [CTRL_W-1:0] {
        CMD_KERNEL   = 3'b000,
        CMD_LEN      = 3'b001,
        CMD_IMG      = 3'b010,
        CMD_READ     = 3'b011,
        CMD_IMG_LAST = 3'b100
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } gpio_cmd_t;

    // Kernel row counter wraps after the last row of a kernel load cycle.
    function automatic logic [KROW_W-1:0] next_krow(input logic [KROW_W-1:0] row);
        return (row == KROW_W'(KROWS - 1)) ? '0 : row + KROW_W'(1);
    endfunction

endpackage

// File: rtl/gpio_cmd_ctrl_if.sv
// Host GPIO fields plus memory/convolver side signals of the command sequencer.
interface gpio_cmd_ctrl_if
    import conv_ctrl_pkg::*;
;
    logic [DATA_W-1:0] i_gpio_data;
    logic [CTRL_W-1:0] i_gpio_ctrl;
    logic              i_gpio_valid;
    logic [DATA_W-1:0] o_kernel_data;
    logic [1:0]        o_kernel_row;
    logic              o_kernel_we;
    logic [LEN_W-1:0]  o_img_len;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [ADDR_W-1:0] o_mem_waddr;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_raddr;
    logic              o_mem_re;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_conv_start;
    logic              i_conv_done;
    logic [DATA_W-1:0] o_gpio_rdata;
    logic              o_gpio_rvalid;
    logic              o_busy;
    logic              o_err;
    logic              o_led;

    modport slave (
        input  i_gpio_data, i_gpio_ctrl, i_gpio_valid, i_mem_rdata, i_conv_done,
        output o_kernel_data, o_kernel_row, o_kernel_we, o_img_len,
               o_mem_wdata, o_mem_waddr, o_mem_we, o_mem_raddr, o_mem_re,
               o_conv_start, o_gpio_rdata, o_gpio_rvalid, o_busy, o_err, o_led
    );

    modport master (
        output i_gpio_data, i_gpio_ctrl, i_gpio_valid, i_mem_rdata, i_conv_done,
        input  o_kernel_data, o_kernel_row, o_kernel_we, o_img_len,
               o_mem_wdata, o_mem_waddr, o_mem_we, o_mem_raddr, o_mem_re,
               o_conv_start, o_gpio_rdata, o_gpio_rvalid, o_busy, o_err, o_led
    );

endinterface

// File: rtl/gpio_strobe_sync.sv
// Two-flop synchronizer on the host strobe level followed by a rising-edge
// detect; yields one single-cycle strobe per host pulse.
module gpio_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic strobe_c
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= level;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign strobe_c = sync & ~sync_d;

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// Decodes host GPIO commands into kernel loads, frame writes, convolution
// start and result readback; owns the write/read pointers and run state.
module gpio_cmd_ctrl
    import conv_ctrl_pkg::*;
(
    input  logic           i_clock,
    input  logic           i_reset,
    gpio_cmd_ctrl_if.slave bus
);

    logic              strobe_c;
    gpio_cmd_t         cmd;
    state_e            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [KROW_W-1:0] krow;
    logic              wr_full;
    logic              start_pend;

    logic [DATA_W-1:0] kernel_data_q;
    logic [1:0]        kernel_row_q;
    logic              kernel_we_q;
    logic [LEN_W-1:0]  img_len_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_raddr_q;
    logic              mem_re_q;
    logic              conv_start_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              busy_q;
    logic              err_q;

    gpio_strobe_sync u_strobe_sync (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .level    (bus.i_gpio_valid),
        .strobe_c (strobe_c)
    );

    assign cmd.ctrl = bus.i_gpio_ctrl;
    assign cmd.data = bus.i_gpio_data;

    // Command sequencer: state, pointers and all registered outputs.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            wptr          <= '0;
            rptr          <= '0;
            krow          <= '0;
            wr_full       <= 1'b0;
            start_pend    <= 1'b0;
            kernel_data_q <= '0;
            kernel_row_q  <= '0;
            kernel_we_q   <= 1'b0;
            img_len_q     <= '0;
            mem_wdata_q   <= '0;
            mem_waddr_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_raddr_q   <= '0;
            mem_re_q      <= 1'b0;
            conv_start_q  <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            kernel_we_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            conv_start_q <= 1'b0;
            rvalid_q     <= mem_re_q;
            if (rvalid_q) begin
                rdata_q <= bus.i_mem_rdata;
            end

            // Start is issued the cycle after the final image write lands.
            if (start_pend) begin
                start_pend   <= 1'b0;
                conv_start_q <= 1'b1;
                busy_q       <= 1'b1;
                state        <= ST_RUN;
                wptr         <= '0;
                wr_full      <= 1'b0;
            end

            if (state == ST_IDLE && cmd.ctrl == CMD_LEN) begin
                img_len_q <= cmd.data[LEN_W-1:0];
            end

            if (state == ST_RUN && bus.i_conv_done) begin
                state  <= ST_DONE;
                busy_q <= 1'b0;
                rptr   <= '0;
            end

            if (strobe_c) begin
                if (state == ST_RUN) begin
                    err_q <= 1'b1;
                end else begin
                    if (state == ST_DONE && cmd.ctrl != CMD_READ) begin
                        state <= ST_IDLE;
                    end
                    case (cmd.ctrl)
                        CMD_KERNEL: begin
                            kernel_we_q   <= 1'b1;
                            kernel_row_q  <= krow;
                            kernel_data_q <= cmd.data;
                            krow          <= next_krow(krow);
                        end
                        CMD_LEN: begin
                            img_len_q <= cmd.data[LEN_W-1:0];
                        end
                        CMD_IMG, CMD_IMG_LAST: begin
                            // Top address already written: suppress rather than wrap.
                            if (wr_full) begin
                                err_q <= 1'b1;
                            end else begin
                                mem_we_q    <= 1'b1;
                                mem_waddr_q <= wptr;
                                mem_wdata_q <= cmd.data;
                                if (wptr == '1) begin
                                    wr_full <= 1'b1;
                                end else begin
                                    wptr <= wptr + ADDR_W'(1);
                                end
                                if (cmd.ctrl == CMD_IMG_LAST) begin
                                    start_pend <= 1'b1;
                                end
                            end
                        end
                        CMD_READ: begin
                            if (state == ST_DONE) begin
                                mem_re_q    <= 1'b1;
                                mem_raddr_q <= rptr;
                                rptr        <= rptr + ADDR_W'(1);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        default: begin
                            err_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.o_kernel_data = kernel_data_q;
    assign bus.o_kernel_row  = kernel_row_q;
    assign bus.o_kernel_we   = kernel_we_q;
    assign bus.o_img_len     = img_len_q;
    assign bus.o_mem_wdata   = mem_wdata_q;
    assign bus.o_mem_waddr   = mem_waddr_q;
    assign bus.o_mem_we      = mem_we_q;
    assign bus.o_mem_raddr   = mem_raddr_q;
    assign bus.o_mem_re      = mem_re_q;
    assign bus.o_conv_start  = conv_start_q;
    assign bus.o_gpio_rvalid = rvalid_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_err         = err_q;
    assign bus.o_led         = busy_q;

    // Memory read data arrives with the rvalid cycle; pass it through then, hold it after.
    assign bus.o_gpio_rdata  = rvalid_q ? bus.i_mem_rdata : rdata_q;

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Self-checking bench for gpio_cmd_ctrl: table-driven command vectors with a
// queue scoreboard checked by a negedge monitor, plus multi-cycle sequences.
module tb_gpio_cmd_ctrl;
    import conv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gpio_cmd_ctrl_if bus ();

    gpio_cmd_ctrl dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct { logic [1:0] row; logic [23:0] data; } kexp_t;
    typedef struct { logic [9:0] addr; logic [23:0] data; } wexp_t;
    typedef struct { logic [2:0] ctrl; logic [23:0] data; logic [1:0] row; int hi; } kvec_t;
    typedef struct { logic [2:0] ctrl; logic [23:0] data; logic err; logic [9:0] len; } evec_t;

    kexp_t      kq[$];
    wexp_t      wq[$];
    logic [9:0] rq[$];
    logic [23:0] gq[$];
    int         sq[$];

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [0:1023];
    logic        prev_re = 1'b0;
    logic        prev_we = 1'b0;
    kexp_t       mk;
    wexp_t       mw;
    logic [9:0]  mr;
    logic [23:0] mg;
    int          ms;

    kvec_t ktab [4];
    evec_t etab [5];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Frame memory: read data appears the cycle after o_mem_re, garbage otherwise.
    always @(posedge clk) begin
        if (bus.o_mem_we === 1'b1) mem[bus.o_mem_waddr] <= bus.o_mem_wdata;
        bus.i_mem_rdata <= (bus.o_mem_re === 1'b1) ? mem[bus.o_mem_raddr] : 24'hBADBAD;
    end

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.o_kernel_we === 1'b1) begin
                if (kq.size() == 0) chk("kernel_unexpected_cnt", 32'(kq.size()), 1);
                else begin
                    mk = kq.pop_front();
                    chk("kernel_row", 32'(bus.o_kernel_row), 32'(mk.row));
                    chk("kernel_data", 32'(bus.o_kernel_data), 32'(mk.data));
                end
            end
            if (bus.o_mem_we === 1'b1) begin
                if (wq.size() == 0) chk("write_unexpected_cnt", 32'(wq.size()), 1);
                else begin
                    mw = wq.pop_front();
                    chk("mem_waddr", 32'(bus.o_mem_waddr), 32'(mw.addr));
                    chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(mw.data));
                end
            end
            if (bus.o_mem_re === 1'b1) begin
                if (rq.size() == 0) chk("read_unexpected_cnt", 32'(rq.size()), 1);
                else begin
                    mr = rq.pop_front();
                    chk("mem_raddr", 32'(bus.o_mem_raddr), 32'(mr));
                end
            end
            if (prev_re) chk("rvalid_latency", 32'(bus.o_gpio_rvalid), 1);
            if (bus.o_gpio_rvalid === 1'b1) begin
                chk("rvalid_after_re", 32'(prev_re), 1);
                if (gq.size() == 0) chk("rvalid_unexpected_cnt", 32'(gq.size()), 1);
                else begin
                    mg = gq.pop_front();
                    chk("gpio_rdata", 32'(bus.o_gpio_rdata), 32'(mg));
                end
            end
            if (bus.o_conv_start === 1'b1) begin
                if (sq.size() == 0) chk("start_unexpected_cnt", 32'(sq.size()), 1);
                else begin
                    ms = sq.pop_front();
                    chk("start_after_last_write", 32'(prev_we), 1);
                    chk("busy_with_start", 32'(bus.o_busy), 1);
                end
            end
            prev_re = (bus.o_mem_re === 1'b1);
            prev_we = (bus.o_mem_we === 1'b1);
        end else begin
            prev_re = 1'b0;
            prev_we = 1'b0;
        end
    end

    task automatic pulse(input logic [2:0] c, input logic [23:0] d, input int hi);
        @(negedge clk);
        bus.i_gpio_ctrl  = c;
        bus.i_gpio_data  = d;
        bus.i_gpio_valid = 1'b1;
        repeat (hi) @(negedge clk);
        bus.i_gpio_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        bus.i_gpio_valid = 1'b0;
        bus.i_gpio_ctrl  = 3'b000;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},       32'(bus.o_busy), 0);
        chk({tag, "_led"},        32'(bus.o_led), 0);
        chk({tag, "_err"},        32'(bus.o_err), 0);
        chk({tag, "_img_len"},    32'(bus.o_img_len), 0);
        chk({tag, "_kdata"},      32'(bus.o_kernel_data), 0);
        chk({tag, "_krow"},       32'(bus.o_kernel_row), 0);
        chk({tag, "_waddr"},      32'(bus.o_mem_waddr), 0);
        chk({tag, "_wdata"},      32'(bus.o_mem_wdata), 0);
        chk({tag, "_raddr"},      32'(bus.o_mem_raddr), 0);
        chk({tag, "_gpio_rdata"}, 32'(bus.o_gpio_rdata), 0);
        chk({tag, "_pulses"}, 32'({bus.o_kernel_we, bus.o_mem_we, bus.o_mem_re,
                                    bus.o_conv_start, bus.o_gpio_rvalid}), 0);
    endtask

    task automatic drain_chk(input string tag);
        chk({tag, "_kq_left"}, 32'(kq.size()), 0);
        chk({tag, "_wq_left"}, 32'(wq.size()), 0);
        chk({tag, "_rq_left"}, 32'(rq.size()), 0);
        chk({tag, "_gq_left"}, 32'(gq.size()), 0);
        chk({tag, "_sq_left"}, 32'(sq.size()), 0);
    endtask

    initial begin
        ktab[0] = '{3'b000, 24'h000000, 2'd0, 1};
        ktab[1] = '{3'b000, 24'h000010, 2'd1, 2};
        ktab[2] = '{3'b000, 24'h000000, 2'd2, 3};
        ktab[3] = '{3'b000, 24'h5A5A5A, 2'd0, 1};
        etab[0] = '{3'b101, 24'h000011, 1'b1, 10'h000};
        etab[1] = '{3'b110, 24'h000022, 1'b1, 10'h000};
        etab[2] = '{3'b111, 24'h000033, 1'b1, 10'h000};
        etab[3] = '{3'b011, 24'h000044, 1'b1, 10'h000};
        etab[4] = '{3'b001, 24'h0007FF, 1'b0, 10'h3FF};
        for (int i = 0; i < 1024; i++) mem[i] = 24'h0;

        bus.i_gpio_data  = '0;
        bus.i_gpio_ctrl  = '0;
        bus.i_gpio_valid = 1'b0;
        bus.i_conv_done  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("por");

        // Reset in the middle of RUN must not reissue the start.
        wq.push_back('{10'd0, 24'hABCDEF});
        sq.push_back(1);
        pulse(CMD_IMG_LAST, 24'hABCDEF, 2);
        chk("run_busy", 32'(bus.o_busy), 1);
        reset_dut();
        check_reset_outputs("midrun");
        repeat (8) @(negedge clk);
        chk("midrun_busy_after", 32'(bus.o_busy), 0);
        drain_chk("midrun");

        // Kernel rows wrap 0,1,2,0.
        foreach (ktab[i]) begin
            kq.push_back('{ktab[i].row, ktab[i].data});
            pulse(ktab[i].ctrl, ktab[i].data, ktab[i].hi);
        end
        chk("kernel_err", 32'(bus.o_err), 0);
        drain_chk("kernel");

        // Length loads without a strobe while ctrl is LEN in IDLE.
        @(negedge clk);
        bus.i_gpio_ctrl = CMD_LEN;
        bus.i_gpio_data = 24'h00000A;
        repeat (2) @(negedge clk);
        chk("img_len_level", 32'(bus.o_img_len), 10);

        for (int i = 0; i < 39; i++) begin
            wq.push_back('{10'(i), 24'(i)});
            pulse(CMD_IMG, 24'(i), (i % 3) + 1);
        end
        wq.push_back('{10'd39, 24'h27});
        sq.push_back(1);
        pulse(CMD_IMG_LAST, 24'h27, 1);
        chk("load_busy", 32'(bus.o_busy), 1);
        chk("load_led", 32'(bus.o_led), 1);
        chk("load_err", 32'(bus.o_err), 0);
        chk("img_len_held", 32'(bus.o_img_len), 10);
        drain_chk("load");

        pulse(CMD_IMG, 24'h000055, 1);
        chk("run_strobe_err", 32'(bus.o_err), 1);
        chk("run_strobe_busy", 32'(bus.o_busy), 1);
        @(negedge clk);
        bus.i_conv_done = 1'b1;
        @(negedge clk);
        bus.i_conv_done = 1'b0;
        chk("done_busy", 32'(bus.o_busy), 0);
        chk("done_led", 32'(bus.o_led), 0);

        for (int i = 0; i < 40; i++) begin
            rq.push_back(10'(i));
            gq.push_back(24'(i));
            pulse(CMD_READ, 24'h0, (i % 3) + 1);
        end
        chk("rdata_hold", 32'(bus.o_gpio_rdata), 39);
        chk("read_busy", 32'(bus.o_busy), 0);
        drain_chk("read");

        // Protocol errors in IDLE plus a LEN strobe truncated to LEN_W bits.
        foreach (etab[i]) begin
            reset_dut();
            pulse(etab[i].ctrl, etab[i].data, 1);
            chk("etab_err", 32'(bus.o_err), 32'(etab[i].err));
            chk("etab_len", 32'(bus.o_img_len), 32'(etab[i].len));
        end
        drain_chk("etab");

        // Fill every address, then the overflow write is refused without wrapping.
        reset_dut();
        for (int i = 0; i < 1024; i++) begin
            wq.push_back('{10'(i), 24'(i + 256)});
            pulse(CMD_IMG, 24'(i + 256), 1);
        end
        chk("full_err_before", 32'(bus.o_err), 0);
        pulse(CMD_IMG, 24'h000077, 1);
        chk("overflow_err", 32'(bus.o_err), 1);
        pulse(CMD_IMG_LAST, 24'h000078, 1);
        repeat (4) @(negedge clk);
        chk("overflow_no_run", 32'(bus.o_busy), 0);
        drain_chk("overflow");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
